// File: rtl/inst_queue_pkg.sv
// Shared types and constants for the instruction queue behind fetch.
// The optional INST_QUEUE_PERF_EN build adds saturating performance counters.
package inst_queue_pkg;

  localparam int IQ_DEPTH = 16;
  localparam int IQ_SS    = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  typedef enum logic {
    FT_VALID = 1'b0,
    FT_STALE = 1'b1
  } ft_state_e;

  function automatic logic [31:0] sat_add32(input logic [31:0] base, input logic [31:0] inc);
    logic [32:0] sum;
    sum = {1'b0, base} + {1'b0, inc};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/inst_queue_if.sv
// Fetch-response / decode-dequeue bundle of the instruction queue.
// The queue uses the slave modport; its environment uses master.
interface inst_queue_if #(
  parameter int SS    = 2,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                 imem_resp;
  logic [31:0]          imem_rdata;
  logic [31:0]          resp_pc;
  logic                 flush;
  logic                 stall_inst;
  logic                 valid_request;
  logic [SS-1:0]        deq_valid;
  logic [SS-1:0][31:0]  deq_pc;
  logic [SS-1:0][31:0]  deq_inst;
  logic                 deq_ready;
  logic [CW-1:0]        count;

  modport master (
    output imem_resp, imem_rdata, resp_pc, flush, deq_ready,
    input  stall_inst, valid_request, deq_valid, deq_pc, deq_inst, count
  );

  modport slave (
    input  imem_resp, imem_rdata, resp_pc, flush, deq_ready,
    output stall_inst, valid_request, deq_valid, deq_pc, deq_inst, count
  );
endinterface

// File: rtl/inst_queue_flush_tracker.sv
// Tracks whether the outstanding imem request predates a flush, so its
// response can be discarded (valid_request = 0 while stale).
module iq_flush_tracker
  import inst_queue_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic imem_resp,
  output logic valid_request
);

  ft_state_e state;
  ft_state_e state_nxt;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FT_VALID;
    end else begin
      state <= state_nxt;
    end
  end

  // A flush with no response in the same cycle leaves a request in flight.
  always_comb begin
    state_nxt = state;
    case (state)
      FT_VALID: begin
        if (flush && !imem_resp) begin
          state_nxt = FT_STALE;
        end else begin
          state_nxt = FT_VALID;
        end
      end
      FT_STALE: begin
        if (imem_resp) begin
          state_nxt = FT_VALID;
        end else begin
          state_nxt = FT_STALE;
        end
      end
      default: state_nxt = FT_VALID;
    endcase
  end

  assign valid_request = (state == FT_VALID);

endmodule

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: circular buffer of {pc, inst},
// up to SS oldest entries presented per cycle. Optional INST_QUEUE_PERF_EN.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int SS    = IQ_SS,
  parameter int DEPTH = IQ_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  inst_queue_if.slave iq
`ifdef INST_QUEUE_PERF_EN
  ,
  output logic [31:0] perf_full_cycles,
  output logic [31:0] perf_flush_drops
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t          mem [DEPTH];
  logic [AW-1:0]         head;
  logic [AW-1:0]         tail;
  logic [CW-1:0]         occ;
  logic                  full;
  logic                  enq;
  logic [SS-1:0]         lane_valid;
  logic [SS-1:0][31:0]   lane_pc;
  logic [SS-1:0][31:0]   lane_inst;
  logic [CW-1:0]         deq_cnt;
  logic                  valid_request;

  iq_flush_tracker u_flush_tracker (
    .clk           (clk),
    .rst           (rst),
    .flush         (iq.flush),
    .imem_resp     (iq.imem_resp),
    .valid_request (valid_request)
  );

  // Full is judged on registered occupancy only; a same-cycle pop earns no credit.
  assign full = (occ == CW'(DEPTH));
  assign enq  = iq.imem_resp & valid_request & ~iq.flush & ~full;

  // Lane views of the oldest entries and the number consumed this cycle.
  always_comb begin
    lane_valid = '0;
    lane_pc    = '0;
    lane_inst  = '0;
    deq_cnt    = '0;
    for (int i = 0; i < SS; i++) begin
      lane_valid[i] = (CW'(i) < occ) & ~iq.flush;
      lane_pc[i]    = mem[head + AW'(i)].pc;
      lane_inst[i]  = mem[head + AW'(i)].inst;
      if (iq.deq_ready && lane_valid[i]) begin
        deq_cnt = deq_cnt + CW'(1);
      end else begin
        deq_cnt = deq_cnt;
      end
    end
  end

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem[tail] <= '{pc: iq.resp_pc, inst: iq.imem_rdata};
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst || iq.flush) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      head <= head + deq_cnt[AW-1:0];
      tail <= tail + AW'(enq);
      occ  <= occ + CW'(enq) - deq_cnt;
    end
  end

`ifdef INST_QUEUE_PERF_EN
  // Saturating full-cycle and flush-discard counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_full_cycles <= 32'd0;
      perf_flush_drops <= 32'd0;
    end else begin
      if (full) begin
        perf_full_cycles <= sat_add32(perf_full_cycles, 32'd1);
      end
      if (iq.flush) begin
        perf_flush_drops <= sat_add32(perf_flush_drops, 32'(occ));
      end
    end
  end
`endif

  assign iq.stall_inst    = full;
  assign iq.valid_request = valid_request;
  assign iq.deq_valid     = lane_valid;
  assign iq.deq_pc        = lane_pc;
  assign iq.deq_inst      = lane_inst;
  assign iq.count         = occ;

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: directed responses push expected {pc,inst};
// a negedge monitor pops and compares every lane decode consumes.
module tb_inst_queue;
  import inst_queue_pkg::*;

  localparam int SS    = 2;
  localparam int DEPTH = 16;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;
  logic [63:0] exp_q [$];

  inst_queue_if #(.SS(SS), .DEPTH(DEPTH)) ifc ();

`ifdef INST_QUEUE_PERF_EN
  logic [31:0] perf_full_cycles;
  logic [31:0] perf_flush_drops;
`endif

  inst_queue #(.SS(SS), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .iq  (ifc.slave)
`ifdef INST_QUEUE_PERF_EN
    ,
    .perf_full_cycles (perf_full_cycles),
    .perf_flush_drops (perf_flush_drops)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // One cycle of stimulus applied just after the rising edge.
  task automatic cyc(input logic resp, input logic [31:0] pc, input logic fl,
                     input logic rdy, input logic acc);
    @(posedge clk);
    #1;
    ifc.imem_resp  = resp;
    ifc.resp_pc    = pc;
    ifc.imem_rdata = inst_of(pc);
    ifc.flush      = fl;
    ifc.deq_ready  = rdy;
    if (fl) exp_q.delete();
    if (acc) exp_q.push_back({pc, inst_of(pc)});
  endtask

  task automatic idle();
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    ifc.imem_resp = 1'b0;
    ifc.flush     = 1'b0;
    ifc.deq_ready = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: every consumed lane must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && ifc.deq_ready) begin
      for (int i = 0; i < SS; i++) begin
        if (ifc.deq_valid[i]) begin
          if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL mon_extra: got pc %0h expected none", ifc.deq_pc[i]);
          end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            chk("mon_entry", {ifc.deq_pc[i], ifc.deq_inst[i]}, e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    rst = 1'b1;
    ifc.imem_resp = 1'b0; ifc.imem_rdata = 32'd0; ifc.resp_pc = 32'd0;
    ifc.flush = 1'b0; ifc.deq_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_count", 64'(ifc.count), 64'd0);
    chk("rst_stall", 64'(ifc.stall_inst), 64'd0);
    chk("rst_vreq", 64'(ifc.valid_request), 64'd1);
    chk("rst_deq_valid", 64'(ifc.deq_valid), 64'd0);

    // Three responses held back from decode.
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h6000_0000 + 32'(4*i), 1'b0, 1'b0, 1'b1);
    idle();
    @(negedge clk);
    chk("t1_count", 64'(ifc.count), 64'd3);
    chk("t1_deq_valid", 64'(ifc.deq_valid), 64'd3);
    chk("t1_pc0", 64'(ifc.deq_pc[0]), 64'h6000_0000);
    chk("t1_pc1", 64'(ifc.deq_pc[1]), 64'h6000_0004);
    drain(2);
    idle();
    @(negedge clk);
    chk("t1_empty", 64'(ifc.count), 64'd0);

    // Fill to DEPTH, then a dropped 17th response.
    for (int i = 0; i < 16; i++) cyc(1'b1, 32'h6100_0000 + 32'(4*i), 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h6100_0040, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t2_stall_full", 64'(ifc.stall_inst), 64'd1);
    idle();
    @(negedge clk);
    chk("t2_count_full", 64'(ifc.count), 64'd16);
    drain(1);
    idle();
    @(negedge clk);
    chk("t2_count_14", 64'(ifc.count), 64'd14);
    chk("t2_stall_off", 64'(ifc.stall_inst), 64'd0);
    drain(7);
    idle();
    @(negedge clk);
    chk("t2_empty", 64'(ifc.count), 64'd0);

    // Wrap-around with periodic two-wide dequeue.
    for (int i = 0; i < 20; i++)
      cyc(1'b1, 32'h6200_0000 + 32'(4*i), 1'b0, (i % 3 == 2), 1'b1);
    drain(8);
    idle();
    @(negedge clk);
    chk("t3_empty", 64'(ifc.count), 64'd0);
    chk("t3_sb_empty", 64'(exp_q.size()), 64'd0);

    // Flush at count 5 with no response: next response is stale.
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h6300_0000 + 32'(4*i), 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("t4_count5", 64'(ifc.count), 64'd5);
    chk("t4_flush_mask", 64'(ifc.deq_valid), 64'd0);
    cyc(1'b1, 32'h6000_0040, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t4_count0", 64'(ifc.count), 64'd0);
    chk("t4_vreq0", 64'(ifc.valid_request), 64'd0);
    cyc(1'b1, 32'h6000_0100, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("t4_vreq1", 64'(ifc.valid_request), 64'd1);
    idle();
    @(negedge clk);
    chk("t4_count1", 64'(ifc.count), 64'd1);
    chk("t4_lane0", 64'(ifc.deq_valid), 64'd1);
    chk("t4_pc", 64'(ifc.deq_pc[0]), 64'h6000_0100);
    drain(1);

    // Flush coincident with a response.
    for (int i = 0; i < 2; i++) cyc(1'b1, 32'h6400_0000 + 32'(4*i), 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h6000_0200, 1'b1, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    chk("t5_count0", 64'(ifc.count), 64'd0);
    chk("t5_vreq", 64'(ifc.valid_request), 64'd1);
    chk("t5_deq_valid", 64'(ifc.deq_valid), 64'd0);
`ifdef INST_QUEUE_PERF_EN
    chk("t5_perf_drops", 64'(perf_flush_drops), 64'd7);
`endif
    cyc(1'b1, 32'h6000_0300, 1'b0, 1'b0, 1'b1);
    idle();
    @(negedge clk);
    chk("t5_accept", 64'(ifc.count), 64'd1);
    drain(1);

    // Reset mid-operation: with 7 entries, then while stale.
    for (int i = 0; i < 7; i++) cyc(1'b1, 32'h6500_0000 + 32'(4*i), 1'b0, 1'b0, 1'b1);
    idle();
    @(negedge clk);
    chk("t6_count7", 64'(ifc.count), 64'd7);
    do_reset();
    @(negedge clk);
    chk("t6_count0", 64'(ifc.count), 64'd0);
    chk("t6_vreq", 64'(ifc.valid_request), 64'd1);
    chk("t6_deq_valid", 64'(ifc.deq_valid), 64'd0);
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    chk("t6_stale", 64'(ifc.valid_request), 64'd0);
    do_reset();
    @(negedge clk);
    chk("t6_vreq_rst", 64'(ifc.valid_request), 64'd1);

    idle();
    @(negedge clk);
    chk("end_sb_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Decoupling FIFO directly downstream of fetch_stage.
- Captures each instruction-memory response with its PC and presents up to SS oldest entries per cycle to decode.
- Back-pressures fetch via stall_inst.
- Generates valid_request so fetch and this block discard a response whose request was issued before a flush.

Parameters:
SS, 2, superscalar width: dequeue lanes per cycle
DEPTH, 16, entry count; power of two, at least 2*SS

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
imem_resp  input  1  instruction memory response valid this cycle
imem_rdata  input  32  instruction word of the response
resp_pc  input  32  PC of the responding request (imem_addr registered by the caller)
flush  input  1  mispredict/redirect from commit; empties the queue
stall_inst  output  1  queue full; fetch holds its PC
valid_request  output  1  0 = the response currently outstanding is stale
deq_valid  output  SS  per-lane entry valid, lane 0 oldest, contiguous from lane 0
deq_pc  output  32xSS  per-lane PC
deq_inst  output  32xSS  per-lane instruction word
deq_ready  input  1  decode consumes every lane with deq_valid=1 this cycle
count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Clock and reset: one clock clk. Reset is synchronous and active-high on rst.
- Storage: circular buffer of {pc, inst}. head and tail pointers are $clog2(DEPTH) bits and wrap naturally. count is held separately.
- Reset values:
  - head = tail = count = 0
  - stall_inst = 0
  - valid_request = 1
  - deq_valid = 0
  - storage is not reset
- stall_inst = (count == DEPTH). Combinational from registered count. No credit is given for a same-cycle dequeue.
- Enqueue accepted iff imem_resp & valid_request & ~flush & ~stall_inst. The entry is written at tail and tail increments.
- A response arriving while stall_inst=1 is dropped. Fetch does not advance, so it re-requests.
- Dequeue outputs:
  - deq_valid[i] = (i < count) & ~flush
  - lane i reads entry head+i, mod DEPTH
  - read is combinational from storage
- On deq_ready, head advances by popcount(deq_valid). count is updated as +enq -deq in the same cycle.
- Simultaneous enqueue and dequeue at any occupancy is legal. Enqueue into the slot vacated that cycle is not permitted, because full is checked on registered count.
- Flush:
  - next cycle head = tail = count = 0
  - enqueue and dequeue in the flush cycle are suppressed
- valid_request state machine:
  - VALID (valid_request=1):
    - flush & ~imem_resp → STALE (a request is in flight)
    - flush & imem_resp → stays VALID (that response is already discarded by the flush rule)
  - STALE (valid_request=0):
    - imem_resp → VALID; the response is dropped
    - flush with no response → stays STALE
- Reset mid-operation overrides everything. Queue empty, state VALID.
- No X on deq_pc/deq_inst when deq_valid=0 is not required.

Optional Feature:
INST_QUEUE_PERF_EN
- Defined: adds outputs perf_full_cycles (32-bit, counts cycles with stall_inst=1) and perf_flush_drops (32-bit, counts enqueued entries discarded by flush, i.e. count at the flush edge).
  - Both saturate at all-ones.
  - Both reset to 0.
- Undefined: ports and counters absent; no other behaviour change.

Decomposition:
- rv32i_types gains:
  - fetch_entry_t {pc[31:0], inst[31:0]}
  - localparam IQ_DEPTH = 16
- One natural sub-module: iq_flush_tracker, the two-state valid_request FSM.
  - Inputs clk, rst, flush, imem_resp. Output valid_request.
  - Instantiated once.
- Storage and pointers stay in inst_queue.

Test Plan:
- Reset, then imem_resp with resp_pc 0x60000000/04/08 and deq_ready=0 → count=3; deq_valid=2'b11; deq_pc={0x60000004,0x60000000}.
- Fill to 16 with deq_ready=0 → stall_inst=1 after the 16th enqueue; 17th response dropped; count stays 16. Then deq_ready=1 → count=14, stall_inst=0.
- Wrap-around: enqueue 20 entries while dequeuing 2 per cycle → PCs emerge strictly in order across the head wrap; no loss or duplication.
- Flush with count=5 and no response same cycle → next cycle count=0, valid_request=0. Next imem_resp (pc 0x60000040) dropped, valid_request returns to 1. Following response pc 0x60000100 enqueued as lane 0.
- Flush coincident with imem_resp → response dropped, valid_request stays 1, queue empty next cycle.
- rst asserted while count=7 and valid_request=0 → next cycle count=0, valid_request=1, deq_valid=0.
